// File: rtl/bus1_pkg.sv
// bus1 arbiter shared package.
// Opcodes, widths and arbiter FSM states.
package bus1_pkg;

  localparam int TAG_W   = 10;
  localparam int SET_W   = 5;
  localparam int OFF_W   = 4;
  localparam int ADDR_W  = TAG_W + SET_W + OFF_W;
  localparam int ADDR1_W = 15;
  localparam int DATA_W  = 16;
  localparam int CTR1_W  = 3;
  localparam int TIMEOUT = 255;

  localparam logic [2:0] C1_NOP        = 3'd0;
  localparam logic [2:0] C1_READ8      = 3'd1;
  localparam logic [2:0] C1_READ16     = 3'd2;
  localparam logic [2:0] C1_READ32     = 3'd3;
  localparam logic [2:0] C1_INVALIDATE = 3'd4;
  localparam logic [2:0] C1_WRITE8     = 3'd5;
  localparam logic [2:0] C1_WRITE16    = 3'd6;
  localparam logic [2:0] C1_WRITE32    = 3'd7;
  localparam logic [2:0] C1_RESPONSE   = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    CMD1,
    CMD2,
    WAIT_RESP,
    RDATA2,
    TURN
  } state_t;

  function automatic logic c1_legal(
    input logic [2:0] c
  );
    return c inside {
      C1_READ8, C1_READ16, C1_READ32,
      C1_WRITE8, C1_WRITE16, C1_WRITE32,
      C1_INVALIDATE
    };
  endfunction

endpackage

// File: rtl/bus1_arbiter_if.sv
// Per-master request/completion bundle.
// One instance per requester.
interface bus1_arbiter_if
  import bus1_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int CW = CTR1_W
);

  logic          valid;
  logic [CW-1:0] cmd;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          ready;
  logic          done;
  logic          err;
  logic [31:0]   rdata;

  modport master (
    output valid, cmd, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  valid, cmd, addr, wdata,
    output ready, done, err, rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
// last_q=1 after reset so master 0 wins first.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = valid;
    unique case (1'b1)
      (valid == 2'b11): grant = last_q ? 2'b01 : 2'b10;
      default:          grant = valid;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_q <= 1'b1;
    end else if (advance && |grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/bus1_arbiter.sv
// Shares cache bus1 between two masters and runs
// the two-cycle command / response protocol.
module bus1_arbiter
  import bus1_pkg::*;
#(
  parameter int TAG_W   = bus1_pkg::TAG_W,
  parameter int SET_W   = bus1_pkg::SET_W,
  parameter int OFF_W   = bus1_pkg::OFF_W,
  parameter int ADDR1_W = bus1_pkg::ADDR1_W,
  parameter int DATA_W  = bus1_pkg::DATA_W,
  parameter int CTR1_W  = bus1_pkg::CTR1_W,
  parameter int TIMEOUT = bus1_pkg::TIMEOUT
) (
  input  logic               CLK,
  input  logic               RESET,
  bus1_arbiter_if.slave      m0,
  bus1_arbiter_if.slave      m1,
  input  logic [CTR1_W-1:0]  c1_in,
  input  logic [ADDR1_W-1:0] a1_in,
  input  logic [DATA_W-1:0]  d1_in,
  output logic [CTR1_W-1:0]  c1_out,
  output logic [ADDR1_W-1:0] a1_out,
  output logic [DATA_W-1:0]  d1_out,
  output logic               bus_oe,
  output logic               busy
);

  localparam int AW    = TAG_W + SET_W + OFF_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t state, state_nx;

  logic [1:0]        valid;
  logic [1:0]        grant;
  logic              adv;
  logic [CTR1_W-1:0] gcmd;

  logic              owner_q;
  logic [CTR1_W-1:0] cmd_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [DATA_W-1:0] lo_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              fin;
  logic              fin_err;
  logic              fin_owner;
  logic [31:0]       fin_rdata;
  logic              resp;

  logic [31:0]       rd0_q, rd1_q;
  logic              er0_q, er1_q;

  logic              unused_a1;

  assign unused_a1 = ^a1_in;

  assign valid = {m1.valid, m0.valid};
  assign adv   = (state == IDLE) && |valid && !RESET;
  assign gcmd  = grant[1] ? m1.cmd : m0.cmd;
  assign resp  = (c1_in == C1_RESPONSE);

  rr_arbiter2 u_rr (
    .CLK     (CLK),
    .RESET   (RESET),
    .valid   (valid),
    .advance (adv),
    .grant   (grant)
  );

  assign m0.ready = adv & grant[0];
  assign m1.ready = adv & grant[1];

  always_comb begin
    state_nx  = state;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_owner = owner_q;
    fin_rdata = '0;
    case (state)
      IDLE: begin
        fin_owner = grant[1];
        if (adv) begin
          if (c1_legal(gcmd)) begin
            state_nx = CMD1;
          end else begin
            state_nx = TURN;
            fin      = 1'b1;
            fin_err  = 1'b1;
          end
        end
      end
      CMD1: state_nx = CMD2;
      CMD2: state_nx = WAIT_RESP;
      WAIT_RESP: begin
        if (resp) begin
          if (cmd_q == C1_READ32) begin
            state_nx = RDATA2;
          end else begin
            state_nx = TURN;
            fin      = 1'b1;
            unique case (1'b1)
              (cmd_q == C1_READ8):
                fin_rdata = 32'(d1_in[7:0]);
              (cmd_q == C1_READ16):
                fin_rdata = 32'(d1_in);
              default:
                fin_rdata = '0;
            endcase
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_nx = TURN;
          fin      = 1'b1;
          fin_err  = 1'b1;
        end
      end
      RDATA2: begin
        state_nx  = TURN;
        fin       = 1'b1;
        fin_rdata = 32'({d1_in, lo_q});
      end
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      er0_q   <= 1'b0;
      er1_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (adv) begin
        owner_q <= grant[1];
        cmd_q   <= gcmd;
        addr_q  <= grant[1] ? m1.addr  : m0.addr;
        wdata_q <= grant[1] ? m1.wdata : m0.wdata;
      end
      if (state == WAIT_RESP) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
      if (state == WAIT_RESP && resp) begin
        lo_q <= d1_in;
      end
      if (fin) begin
        if (fin_owner) begin
          rd1_q <= fin_rdata;
          er1_q <= fin_err;
        end else begin
          rd0_q <= fin_rdata;
          er0_q <= fin_err;
        end
      end
    end
  end

  // Drivers are live only for the two command cycles.
  always_comb begin
    bus_oe = 1'b0;
    c1_out = '0;
    a1_out = '0;
    d1_out = '0;
    case (state)
      CMD1: begin
        bus_oe = 1'b1;
        c1_out = cmd_q;
        a1_out = ADDR1_W'(addr_q[AW-1:OFF_W]);
        d1_out = wdata_q[DATA_W-1:0];
      end
      CMD2: begin
        bus_oe = 1'b1;
        c1_out = cmd_q;
        a1_out = ADDR1_W'(addr_q[OFF_W-1:0]);
        d1_out = (cmd_q == C1_WRITE32)
               ? wdata_q[2*DATA_W-1:DATA_W]
               : wdata_q[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  assign m0.done  = (state == TURN) && !owner_q;
  assign m1.done  = (state == TURN) &&  owner_q;
  assign m0.rdata = rd0_q;
  assign m1.rdata = rd1_q;
  assign m0.err   = er0_q;
  assign m1.err   = er1_q;

endmodule

// File: doc/bus1_arbiter.md
Name: bus1_arbiter

Overview:
- Shares the single CPU-side cache bus (C1/A1/D1) between two requesters (master 0, master 1) and sequences the cache's two-cycle command protocol.
- Each master hands over one complete transaction: command, full address and up to 32 bits of write data.
- The block serialises the transaction onto bus1, releases the bus, waits for C1_RESPONSE, collects read data and returns a one-cycle completion.
- It sits between the CPU model(s) and the cache. Only one transaction is outstanding at a time.

Parameters:
- TAG_W, 10, cache tag width
- SET_W, 5, cache set-index width
- OFF_W, 4, line-offset width
- ADDR1_W, 15, A1 width; must be >= max(TAG_W+SET_W, OFF_W)
- DATA_W, 16, D1 width
- CTR1_W, 3, C1 width
- TIMEOUT, 255, maximum cycles spent in WAIT_RESP before error completion

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- mN_valid  in  1  request from master N (N=0,1); held until mN_ready
- mN_cmd  in  CTR1_W  C1 opcode requested
- mN_addr  in  TAG_W+SET_W+OFF_W  byte address {tag,set,offset}
- mN_wdata  in  32  write data; [7:0] is the first byte
- mN_ready  out  1  one-cycle pulse: request accepted
- mN_done  out  1  one-cycle pulse: transaction complete
- mN_err  out  1  valid with mN_done: timeout or illegal opcode
- mN_rdata  out  32  read data, valid with mN_done
- c1_in / a1_in / d1_in  in  CTR1_W / ADDR1_W / DATA_W  resolved bus1 wires
- c1_out / a1_out / d1_out  out  same widths  values driven onto bus1
- bus_oe  out  1  enables the c1/a1/d1 drivers; 0 means high-Z
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0, bus_oe=0 (bus released), state IDLE, last_grant=1 (master 0 wins first), timeout counter 0.
- RESET asserted mid-transaction aborts immediately: bus released, no done pulse, latched request discarded. A master still holding valid is re-arbitrated after reset.
- Legal opcodes: READ8, READ16, READ32, WRITE8, WRITE16, WRITE32, INVALIDATE_LINE.
- Illegal opcodes (NOP, other codes) are accepted, never touch the bus, and complete with done=1, err=1 in the next cycle.
- IDLE:
  - Only one master valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - Grant cycle: pulse mN_ready, latch cmd/addr/wdata/owner, update last_grant, go to CMD1.
- CMD1 (1 cycle): bus_oe=1, c1_out=cmd, a1_out={tag,set}, d1_out=wdata[15:0]. The cache samples these at the closing edge.
- CMD2 (1 cycle): bus_oe=1, c1_out unchanged, a1_out=offset zero-extended. d1_out=wdata[31:16] for WRITE32, otherwise wdata[15:0] held.
- WAIT_RESP: bus_oe=0; the counter increments each cycle.
  - Response cycle (c1_in==C1_RESPONSE): capture data.
    - READ8: rdata={24'b0, d1_in[7:0]}
    - READ16: rdata={16'b0, d1_in}
    - READ32: rdata[15:0]=d1_in, then go to RDATA2
    - Writes/INVALIDATE: rdata=0
  - All opcodes except READ32 go to TURN.
  - c1_in is ignored in every state other than WAIT_RESP.
- RDATA2 (1 cycle): rdata[31:16]=d1_in, go to TURN.
- Timeout: counter reaches TIMEOUT with no response → TURN with err=1, rdata=0.
- TURN (1 cycle): owner's done pulses high, rdata and err valid. This cycle lets the cache release bus1. Next state IDLE.
- Completion latency: done arrives exactly 1 cycle after the response cycle, or 2 for READ32.
- Minimum gap between consecutive commands on C1 is therefore 1 idle cycle.
- A new request may only be granted in IDLE. mN_valid asserted while busy is simply held.
- rdata and err hold their value until the next done for that master.

Decomposition:
- Shared package bus1_pkg holds:
  - C1 opcode constants: NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7, RESPONSE=7.
  - Width constants.
  - Enum state_t {IDLE, CMD1, CMD2, WAIT_RESP, RDATA2, TURN}.
- One natural sub-module: rr_arbiter2 (2-way round-robin: valid[1:0], advance → grant[1:0], last-grant register).

Test Plan:
- m0 READ16 addr {tag=3,set=5,off=2}; cache responds 4 cycles after CMD2 with d1=0xBEEF → a1 shows 0x065 then 0x002; m0_done at response+1; m0_rdata=0x0000BEEF, err=0.
- m1 WRITE32 wdata=0xDEADBEEF → d1_out 0xBEEF in CMD1, 0xDEAD in CMD2; bus_oe drops after CMD2; m1_done 1 cycle after response.
- m0 and m1 both valid with READ8 in the same cycle, twice back-to-back → grants in order m0, m1, m0, m1; exactly one idle cycle between C1 commands.
- READ32 with response data 0x1234 then 0x5678 → rdata=0x56781234.
- No response → m0_done with err=1, rdata=0 exactly TIMEOUT+1 cycles after entering WAIT_RESP; m1 is granted next.
- RESET pulsed during WAIT_RESP → bus_oe=0 at once, no done; m1 (still valid) granted first after reset.
- m1_cmd=NOP → m1_ready, then done+err the next cycle; c1_out never driven.
